dec_stage: RTL and testbench
============================

// Module: dec_stage
// PURPOSE
//  Pipelined RV32I/RV32E decode stage: decodes one instruction, reads the integer register file,
//  resolves branch conditions and registers the result toward EX behind a valid/ready handshake.
//  A busy-bit scoreboard stalls RAW/WAW hazards against in-flight writers; a flush port kills the staged instr.
//  Sits between fetch and the ALU/EX stage; receives write-back from the WB stage.
// PARAMETERS
//  XLEN    32                 datapath width (32 only legal for RV32; kept for the 64-bit successor)
//  NREGS   32                 architectural registers: 32 = RV32I, 16 = RV32E
//  ADDR_W  $clog2(NREGS)      register index width used internally
// PORTS
//  clk            in   1     clock, all state on rising edge
//  rst            in   1     synchronous reset, active high
//  in_valid       in   1     fetch offers in_instr/in_pc
//  in_ready       out  1     decode accepts this cycle
//  in_instr       in   32    instruction word
//  in_pc          in   XLEN  pc of in_instr
//  flush          in   1     kill staged instruction, block acceptance this cycle
//  wb_en          in   1     register write-back strobe
//  wb_addr        in   5     write-back index
//  wb_data        in   XLEN  write-back data
//  out_valid      out  1     staged decode result valid
//  ex_ready       in   1     EX accepts staged result
//  out_pc         out  XLEN  staged pc
//  out_alu_a      out  XLEN  op_a_sel ? pc : rs1 value
//  out_alu_b      out  XLEN  op_b_sel ? imm : rs2 value
//  out_rs2_val    out  XLEN  rs2 value (store data)
//  out_imm        out  32    sign-extended immediate (I/S/B/U/J)
//  out_alu_op     out  5     ALU operation code (team ALU encoding)
//  out_rd_addr    out  5     destination index
//  out_rd_sel     out  2     WB source: 0 ALU, 1 mem, 2 pc+4
//  out_reg_write / out_mem_read / out_mem_write / out_jal / out_jalr / out_branch_taken  out 1 each
//  out_illegal    out  1     unsupported opcode or index >= NREGS
// BEHAVIOUR
//  - Reset: every out_* = 0, out_valid = 0, all NREGS registers = 0, busy vector = 0. in_ready = 0 during rst.
//  - Regfile: NREGS x XLEN, x0 reads 0 and ignores writes; write on rising edge when wb_en && wb_addr<NREGS.
//    Read is combinational; same-cycle write is NOT visible to reads (except via bypass, see CONFIGURATION).
//  - Decode is combinational from in_instr; rs1 used by all except LUI/AUIPC/JAL; rs2 used by R/S/B types.
//  - hazard = (rs1 used && busy[rs1]) || (rs2 used && busy[rs2]) || (reg_write && busy[rd]); x0 never busy.
//  - in_ready = !rst && !flush && !hazard && (!out_valid || ex_ready).
//  - Accept (in_valid && in_ready): stage register loads all out_* next edge, out_valid=1; latency 1 cycle.
//    If accepted instr has reg_write && rd!=0, busy[rd] set on same edge.
//  - Hold: out_valid && !ex_ready -> all out_* stable. EX handoff with no accept -> out_valid=0.
//  - Busy clear: wb_en && wb_addr!=0 clears busy[wb_addr]. Set and clear on same index same edge: set wins.
//  - Flush: out_valid=0 next edge regardless of ex_ready; busy[out_rd_addr] cleared if staged instr had
//    reg_write; instrs already past EX still write back normally; no accept during flush.
//  - Branch: BEQ/BNE/BLT/BGE/BLTU/BGEU compared on register values; result in out_branch_taken, 0 for non-B.
//  - Illegal: out_illegal=1, reg_write/mem_read/mem_write/jal/jalr forced 0; instr still staged, sets no busy bit.
//  - RV32E (NREGS=16): any used rs/rd index >= 16 is illegal.
// CONFIGURATION
//  DEC_BYPASS_EN defined: if wb_en && wb_addr==rs (rs!=0) in a cycle, operand takes wb_data and
//    busy[rs] is treated clear that cycle -> dependent instr accepted same cycle as its write-back.
//  Undefined: dependent instr waits until busy bit is cleared; accepted the cycle after write-back,
//    reading the written value from the regfile.
// TESTING
//  1 rst 2 cycles; ADDI x1,x0,5 with ex_ready=1 -> out_valid next cycle, out_alu_b=5, busy[1]=1.
//  2 ADD x2,x1,x1 with busy[1]=1 -> in_ready=0; wb_en,wb_addr=1,wb_data=5 -> bypass: accepted that cycle,
//    out_alu_a=out_alu_b=5; no bypass: accepted next cycle with the same values.
//  3 ex_ready=0 for 3 cycles with out_valid=1 -> out_* unchanged, in_ready=0; release -> next instr staged.
//  4 BLT x3,x4 with x3=-1,x4=1 -> out_branch_taken=1; BLTU same operands -> 0.
//  5 flush while staged LW x5 -> out_valid=0 next cycle, busy[5]=0, in_ready back to 1 the cycle after.
//  6 NREGS=16: ADD x17,x1,x2 -> out_illegal=1, out_reg_write=0, busy vector unchanged.

Source files
------------

// File: rtl/dec_stage.sv
// RV32I/RV32E decode stage: decode, regfile read, branch resolve, busy-bit hazards.
// Optional macro DEC_BYPASS_EN forwards same-cycle write-back data to operands.
module dec_stage #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_alu_a,
  output logic [XLEN-1:0] out_alu_b,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [31:0]     out_imm,
  output logic [4:0]      out_alu_op,
  output logic [4:0]      out_rd_addr,
  output logic [1:0]      out_rd_sel,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_jal,
  output logic            out_jalr,
  output logic            out_branch_taken,
  output logic            out_illegal
);

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_PASSB = 5'd10;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] rs2_val;
    logic [31:0]     imm;
    logic [4:0]      alu_op;
    logic [4:0]      rd_addr;
    logic [1:0]      rd_sel;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            jal;
    logic            jalr;
    logic            br_taken;
    logic            illegal;
  } id_ex_t;

  id_ex_t st;
  id_ex_t nx;

  logic [XLEN-1:0] rf [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nx;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign f3     = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign f7     = in_instr[31:25];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0};

  function automatic logic [4:0] alu_of(input logic [2:0] fn, input logic alt);
    logic [4:0] op;
    case (fn)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [31:0] imm;
  logic [4:0]  alu_op;
  logic [1:0]  rd_sel;
  logic rw, mr, mw, jal, jalr;
  logic a_pc, b_imm, use1, use2, is_br, bad_op;

  always_comb begin
    imm    = '0;
    alu_op = ALU_ADD;
    rd_sel = 2'd0;
    rw     = 1'b0;
    mr     = 1'b0;
    mw     = 1'b0;
    jal    = 1'b0;
    jalr   = 1'b0;
    a_pc   = 1'b0;
    b_imm  = 1'b0;
    use1   = 1'b0;
    use2   = 1'b0;
    is_br  = 1'b0;
    bad_op = 1'b0;
    case (opcode)
      7'b0110111: begin
        rw = 1'b1; imm = imm_u; b_imm = 1'b1; alu_op = ALU_PASSB;
      end
      7'b0010111: begin
        rw = 1'b1; imm = imm_u; a_pc = 1'b1; b_imm = 1'b1;
      end
      7'b1101111: begin
        rw = 1'b1; jal = 1'b1; rd_sel = 2'd2;
        imm = imm_j; a_pc = 1'b1; b_imm = 1'b1;
      end
      7'b1100111: begin
        rw = 1'b1; jalr = 1'b1; rd_sel = 2'd2;
        imm = imm_i; use1 = 1'b1; b_imm = 1'b1;
        bad_op = (f3 != 3'b000);
      end
      7'b1100011: begin
        is_br = 1'b1; imm = imm_b; a_pc = 1'b1; b_imm = 1'b1;
        use1 = 1'b1; use2 = 1'b1;
        bad_op = (f3 == 3'b010) || (f3 == 3'b011);
      end
      7'b0000011: begin
        rw = 1'b1; mr = 1'b1; rd_sel = 2'd1;
        imm = imm_i; use1 = 1'b1; b_imm = 1'b1;
        bad_op = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      7'b0100011: begin
        mw = 1'b1; imm = imm_s; use1 = 1'b1; use2 = 1'b1; b_imm = 1'b1;
        bad_op = (f3 > 3'b010);
      end
      7'b0010011: begin
        rw = 1'b1; imm = imm_i; use1 = 1'b1; b_imm = 1'b1;
        alu_op = alu_of(f3, (f3 == 3'b101) && f7[5]);
        bad_op = ((f3 == 3'b001) && (f7 != 7'b0))
              || ((f3 == 3'b101) && (f7 != 7'b0) && (f7 != 7'b0100000));
      end
      7'b0110011: begin
        rw = 1'b1; use1 = 1'b1; use2 = 1'b1;
        alu_op = alu_of(f3, f7[5]);
        bad_op = !((f7 == 7'b0)
              || ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      default: bad_op = 1'b1;
    endcase
  end

  logic ok1, ok2, okd, wb_ok;

  assign ok1   = int'(rs1) < NREGS;
  assign ok2   = int'(rs2) < NREGS;
  assign okd   = int'(rd) < NREGS;
  assign wb_ok = int'(wb_addr) < NREGS;

  logic [XLEN-1:0] rs1_rf, rs2_rf;

  always_comb begin
    rs1_rf = '0;
    rs2_rf = '0;
    if (ok1 && rs1 != 5'd0) rs1_rf = rf[rs1[ADDR_W-1:0]];
    if (ok2 && rs2 != 5'd0) rs2_rf = rf[rs2[ADDR_W-1:0]];
  end

  logic busy1, busy2, busyd;

  assign busy1 = ok1 && busy[rs1[ADDR_W-1:0]];
  assign busy2 = ok2 && busy[rs2[ADDR_W-1:0]];
  assign busyd = okd && busy[rd[ADDR_W-1:0]];

  logic [XLEN-1:0] rs1_val, rs2_val;
  logic busy1_eff, busy2_eff;

`ifdef DEC_BYPASS_EN
  logic byp1, byp2;
  assign byp1      = wb_en && (wb_addr == rs1) && (rs1 != 5'd0);
  assign byp2      = wb_en && (wb_addr == rs2) && (rs2 != 5'd0);
  assign rs1_val   = byp1 ? wb_data : rs1_rf;
  assign rs2_val   = byp2 ? wb_data : rs2_rf;
  assign busy1_eff = busy1 && !byp1;
  assign busy2_eff = busy2 && !byp2;
`else
  assign rs1_val   = rs1_rf;
  assign rs2_val   = rs2_rf;
  assign busy1_eff = busy1;
  assign busy2_eff = busy2;
`endif

  logic illegal, reg_write, hazard, accept;
  logic [XLEN-1:0] op1, op2, imm_x;

  assign illegal = bad_op || (use1 && !ok1) || (use2 && !ok2) || (rw && !okd);
  assign reg_write = rw && !illegal;

  assign hazard = !illegal && ((use1 && busy1_eff)
               || (use2 && busy2_eff) || (reg_write && busyd));

  assign in_ready = !rst && !flush && !hazard && (!st.valid || ex_ready);
  assign accept   = in_valid && in_ready;

  assign op1   = use1 ? rs1_val : '0;
  assign op2   = use2 ? rs2_val : '0;
  assign imm_x = XLEN'($signed(imm));

  logic eq, lt, ltu, taken;

  assign eq  = (op1 == op2);
  assign lt  = $signed(op1) < $signed(op2);
  assign ltu = op1 < op2;

  always_comb begin
    taken = 1'b0;
    if (is_br && !illegal) begin
      case (f3)
        3'b000:  taken = eq;
        3'b001:  taken = !eq;
        3'b100:  taken = lt;
        3'b101:  taken = !lt;
        3'b110:  taken = ltu;
        3'b111:  taken = !ltu;
        default: taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    nx           = '0;
    nx.valid     = 1'b1;
    nx.pc        = in_pc;
    nx.alu_a     = a_pc ? in_pc : op1;
    nx.alu_b     = b_imm ? imm_x : op2;
    nx.rs2_val   = op2;
    nx.imm       = imm;
    nx.alu_op    = alu_op;
    nx.rd_addr   = rd;
    nx.rd_sel    = rd_sel;
    nx.reg_write = reg_write;
    nx.mem_read  = mr && !illegal;
    nx.mem_write = mw && !illegal;
    nx.jal       = jal && !illegal;
    nx.jalr      = jalr && !illegal;
    nx.br_taken  = taken;
    nx.illegal   = illegal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= '0;
    end else if (flush) begin
      st.valid <= 1'b0;
    end else if (accept) begin
      st <= nx;
    end else if (ex_ready) begin
      st.valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_en && wb_ok && wb_addr != 5'd0) begin
      rf[wb_addr[ADDR_W-1:0]] <= wb_data;
    end
  end

  // set is applied last so a same-edge set beats a write-back clear
  always_comb begin
    busy_nx = busy;
    if (flush && st.valid && st.reg_write)
      busy_nx[st.rd_addr[ADDR_W-1:0]] = 1'b0;
    if (wb_en && wb_ok && wb_addr != 5'd0)
      busy_nx[wb_addr[ADDR_W-1:0]] = 1'b0;
    if (accept && reg_write && rd != 5'd0)
      busy_nx[rd[ADDR_W-1:0]] = 1'b1;
    busy_nx[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nx;
  end

  assign out_valid        = st.valid;
  assign out_pc           = st.pc;
  assign out_alu_a        = st.alu_a;
  assign out_alu_b        = st.alu_b;
  assign out_rs2_val      = st.rs2_val;
  assign out_imm          = st.imm;
  assign out_alu_op       = st.alu_op;
  assign out_rd_addr      = st.rd_addr;
  assign out_rd_sel       = st.rd_sel;
  assign out_reg_write    = st.reg_write;
  assign out_mem_read     = st.mem_read;
  assign out_mem_write    = st.mem_write;
  assign out_jal          = st.jal;
  assign out_jalr         = st.jalr;
  assign out_branch_taken = st.br_taken;
  assign out_illegal      = st.illegal;

endmodule

// File: tb/tb_dec_stage.sv
// Directed bench for dec_stage: RV32I instance plus an RV32E instance.
// Expectations for the hazard test follow DEC_BYPASS_EN when it is defined.
module tb_dec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, e_valid;
  logic [31:0] in_instr, in_pc;
  logic        flush, wb_en, ex_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_alu_a, out_alu_b, out_rs2_val, out_imm;
  logic [4:0]  out_alu_op, out_rd_addr;
  logic [1:0]  out_rd_sel;
  logic        out_reg_write, out_mem_read, out_mem_write;
  logic        out_jal, out_jalr, out_branch_taken, out_illegal;

  logic        e_ready, e_out_valid;
  logic [31:0] e_pc, e_alu_a, e_alu_b, e_rs2_val, e_imm;
  logic [4:0]  e_alu_op, e_rd_addr;
  logic [1:0]  e_rd_sel;
  logic        e_reg_write, e_mem_read, e_mem_write;
  logic        e_jal, e_jalr, e_taken, e_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dec_stage u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .ex_ready(ex_ready),
    .out_pc(out_pc), .out_alu_a(out_alu_a), .out_alu_b(out_alu_b),
    .out_rs2_val(out_rs2_val), .out_imm(out_imm), .out_alu_op(out_alu_op),
    .out_rd_addr(out_rd_addr), .out_rd_sel(out_rd_sel),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_jal(out_jal), .out_jalr(out_jalr),
    .out_branch_taken(out_branch_taken), .out_illegal(out_illegal)
  );

  dec_stage #(.NREGS(16)) u_e (
    .clk(clk), .rst(rst),
    .in_valid(e_valid), .in_ready(e_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(e_out_valid), .ex_ready(ex_ready),
    .out_pc(e_pc), .out_alu_a(e_alu_a), .out_alu_b(e_alu_b),
    .out_rs2_val(e_rs2_val), .out_imm(e_imm), .out_alu_op(e_alu_op),
    .out_rd_addr(e_rd_addr), .out_rd_sel(e_rd_sel),
    .out_reg_write(e_reg_write), .out_mem_read(e_mem_read),
    .out_mem_write(e_mem_write), .out_jal(e_jal), .out_jalr(e_jalr),
    .out_branch_taken(e_taken), .out_illegal(e_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [4:0] s2,
      input logic [4:0] s1, input logic [2:0] f3, input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_op(input logic [11:0] im, input logic [4:0] s1,
      input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
    return {im, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] b_op(input logic [12:0] im, input logic [4:0] s2,
      input logic [4:0] s1, input logic [2:0] f3);
    return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'b1100011};
  endfunction

  logic [2:0] br_f3 [4];
  logic       br_exp [4];

  initial begin
    br_f3[0] = 3'b100; br_exp[0] = 1'b1;
    br_f3[1] = 3'b110; br_exp[1] = 1'b0;
    br_f3[2] = 3'b001; br_exp[2] = 1'b1;
    br_f3[3] = 3'b101; br_exp[3] = 1'b0;

    rst = 1'b1; in_valid = 1'b0; e_valid = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0; ex_ready = 1'b1;
    step();
    step();
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_alu_b", out_alu_b, 32'd0);
    check("rst_busy", u_dut.busy, 32'd0);

    // ADDI x1,x0,5
    in_instr = i_op(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
    in_pc = 32'h100; in_valid = 1'b1;
    #1;
    check("addi_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("addi_valid", {31'b0, out_valid}, 32'd1);
    check("addi_alu_b", out_alu_b, 32'd5);
    check("addi_alu_a", out_alu_a, 32'd0);
    check("addi_pc", out_pc, 32'h100);
    check("addi_op", {27'b0, out_alu_op}, 32'd0);
    check("addi_rw", {31'b0, out_reg_write}, 32'd1);
    check("addi_busy", u_dut.busy, 32'h2);

    // ADD x2,x1,x1 waits on busy x1
    in_instr = r_op(7'b0, 5'd1, 5'd1, 3'b000, 5'd2);
    in_pc = 32'h104;
    #1;
    check("raw_stall", {31'b0, in_ready}, 32'd0);
    step();
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
    #1;
`ifdef DEC_BYPASS_EN
    check("byp_ready", {31'b0, in_ready}, 32'd1);
    step();
    wb_en = 1'b0;
`else
    check("wb_cycle_stall", {31'b0, in_ready}, 32'd0);
    step();
    wb_en = 1'b0;
    #1;
    check("post_wb_ready", {31'b0, in_ready}, 32'd1);
    step();
`endif
    check("add_alu_a", out_alu_a, 32'd5);
    check("add_alu_b", out_alu_b, 32'd5);
    check("add_rd", {27'b0, out_rd_addr}, 32'd2);
    check("add_busy", u_dut.busy, 32'h4);

    // hold with ex_ready low
    ex_ready = 1'b0;
    in_instr = i_op(12'd7, 5'd0, 3'b000, 5'd6, 7'b0010011);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_ready", {31'b0, in_ready}, 32'd0);
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_rd", {27'b0, out_rd_addr}, 32'd2);
      check("hold_alu_a", out_alu_a, 32'd5);
      step();
    end
    ex_ready = 1'b1;
    #1;
    check("release_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("release_rd", {27'b0, out_rd_addr}, 32'd6);
    check("release_alu_b", out_alu_b, 32'd7);
    check("release_busy", u_dut.busy, 32'h44);

    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hffff_ffff;
    step();
    wb_addr = 5'd4; wb_data = 32'd1;
    step();
    wb_en = 1'b0;
    check("drain_valid", {31'b0, out_valid}, 32'd0);

    // branches on x3=-1, x4=1
    in_valid = 1'b1; in_pc = 32'h200;
    for (int i = 0; i < 4; i++) begin
      in_instr = b_op(13'd16, 5'd4, 5'd3, br_f3[i]);
      step();
      check($sformatf("br_taken_%0d", i), {31'b0, out_branch_taken},
            {31'b0, br_exp[i]});
    end
    check("br_alu_a", out_alu_a, 32'h200);
    check("br_alu_b", out_alu_b, 32'd16);
    check("br_rw", {31'b0, out_reg_write}, 32'd0);

    // LW x5 then flush
    in_instr = i_op(12'd0, 5'd0, 3'b010, 5'd5, 7'b0000011);
    step();
    check("lw_mr", {31'b0, out_mem_read}, 32'd1);
    check("lw_sel", {30'b0, out_rd_sel}, 32'd1);
    check("lw_busy", u_dut.busy, 32'h64);
    ex_ready = 1'b0; flush = 1'b1;
    in_instr = i_op(12'd1, 5'd0, 3'b000, 5'd7, 7'b0010011);
    #1;
    check("flush_ready", {31'b0, in_ready}, 32'd0);
    step();
    flush = 1'b0;
    #1;
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_busy", u_dut.busy, 32'h44);
    check("after_flush_ready", {31'b0, in_ready}, 32'd1);
    ex_ready = 1'b1;
    step();
    check("after_flush_rd", {27'b0, out_rd_addr}, 32'd7);

    // unsupported opcode
    in_instr = 32'hffff_ffff;
    step();
    in_valid = 1'b0;
    check("ill_flag", {31'b0, out_illegal}, 32'd1);
    check("ill_rw", {31'b0, out_reg_write}, 32'd0);
    check("ill_busy", u_dut.busy, 32'hc4);

    // RV32E: x17 out of range
    e_valid = 1'b1;
    in_instr = r_op(7'b0, 5'd2, 5'd1, 3'b000, 5'd17);
    step();
    check("e_ill", {31'b0, e_illegal}, 32'd1);
    check("e_ill_rw", {31'b0, e_reg_write}, 32'd0);
    check("e_ill_busy", {16'b0, u_e.busy}, 32'd0);
    in_instr = r_op(7'b0, 5'd2, 5'd1, 3'b000, 5'd3);
    step();
    e_valid = 1'b0;
    check("e_ok", {31'b0, e_illegal}, 32'd0);
    check("e_ok_rw", {31'b0, e_reg_write}, 32'd1);
    check("e_ok_busy", {16'b0, u_e.busy}, 32'h8);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
